// File: rtl/dac_sample_buffer_pkg.sv
// Shared DAC-path definitions: stream state, midscale constant and round/saturate helper.
package drfm_dac_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    PRIME  = 1'b0,
    STREAM = 1'b1
  } dac_state_e;

  // Offset-binary zero: only the MSB of a w-bit word is set.
  function automatic logic [MAX_W-1:0] midscale(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Adds the rounding bit unless the word is already full scale, so it never wraps to zero.
  function automatic logic [MAX_W-1:0] round_sat(input logic [MAX_W-1:0] top,
                                                 input logic             rnd,
                                                 input int               w);
    logic [MAX_W-1:0] allOnes;
    allOnes = (64'd1 << w) - 64'd1;
    if (!rnd || (top == allOnes)) begin
      return top;
    end
    return top + 64'd1;
  endfunction

endpackage

// File: rtl/dac_sample_buffer_if.sv
// Sample/DAC bus of dac_sample_buffer; master is the upstream driver, slave is the buffer.
interface dac_sample_buffer_if #(
  parameter int IN_W  = 32,
  parameter int DAC_W = 14,
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [IN_W-1:0]  sample_in;
  logic             sample_valid;
  logic             flag_clr;
  logic [DAC_W-1:0] dac_data;
  logic             dac_strobe;
  logic [CNT_W-1:0] fill_level;
  logic             underflow;
  logic             overflow;

  modport master (
    output sample_in, sample_valid, flag_clr,
    input  dac_data, dac_strobe, fill_level, underflow, overflow
  );

  modport slave (
    input  sample_in, sample_valid, flag_clr,
    output dac_data, dac_strobe, fill_level, underflow, overflow
  );

endinterface

// File: rtl/dac_sample_buffer_fifo.sv
// Single-clock FIFO of reduced DAC words; when full, a push is taken only alongside a pop.
module sample_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (doPush && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (doPop && !doPush) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dac_sample_buffer.sv
// Reduces offset-binary samples to DAC width, buffers them and paces them to the DAC.
// Define DAC_ROUND_EN for round-half-up with saturation; otherwise plain truncation.
module dac_sample_buffer
  import drfm_dac_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int DAC_W    = 14,
  parameter int DEPTH    = 16,
  parameter int RATE_DIV = 2
) (
  input  logic               M100CLK,
  input  logic               reset_n,
  dac_sample_buffer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RC_W  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DAC_W-1:0] MIDSCALE    = DAC_W'(midscale(DAC_W));
  localparam logic [RC_W-1:0]  RATE_LAST   = RC_W'(RATE_DIV - 1);
  localparam logic [CNT_W-1:0] PRIME_LEVEL = CNT_W'(DEPTH / 2);

  dac_state_e       state_q;
  logic [RC_W-1:0]  rateCnt_q;
  logic [DAC_W-1:0] dacData_q;
  logic             dacStrobe_q;
  logic             underflow_q, underflow_d;
  logic             overflow_q, overflow_d;

  logic [DAC_W-1:0] reducedWord;
  logic [DAC_W-1:0] fifoHead;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CNT_W-1:0] fifoCount;
  logic             tick;
  logic             popReq;
  logic             underflowSet;
  logic             overflowSet;
  logic             unusedLowBits;

  assign unusedLowBits = ^bus.sample_in[IN_W-DAC_W-1:0];

`ifdef DAC_ROUND_EN
  assign reducedWord = DAC_W'(round_sat(MAX_W'(bus.sample_in[IN_W-1 -: DAC_W]),
                                        bus.sample_in[IN_W-DAC_W-1], DAC_W));
`else
  assign reducedWord = bus.sample_in[IN_W-1 -: DAC_W];
`endif

  sample_fifo #(
    .WIDTH (DAC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (M100CLK),
    .rst_ni  (reset_n),
    .push_i  (bus.sample_valid),
    .pop_i   (popReq),
    .wdata_i (reducedWord),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign tick         = (state_q == STREAM) && (rateCnt_q == RATE_LAST);
  assign popReq       = tick && !fifoEmpty;
  assign underflowSet = tick && fifoEmpty;
  // A full FIFO still takes the write when the same cycle pops the head.
  assign overflowSet  = bus.sample_valid && fifoFull && !popReq;

  always_comb begin
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    if (bus.flag_clr) begin
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
    end
    if (underflowSet) begin
      underflow_d = 1'b1;
    end
    if (overflowSet) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge M100CLK) begin
    if (!reset_n) begin
      state_q     <= PRIME;
      rateCnt_q   <= '0;
      dacData_q   <= MIDSCALE;
      dacStrobe_q <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      dacStrobe_q <= 1'b0;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      case (state_q)
        PRIME: begin
          if (fifoCount >= PRIME_LEVEL) begin
            state_q   <= STREAM;
            rateCnt_q <= '0;
          end
        end
        STREAM: begin
          rateCnt_q <= tick ? '0 : rateCnt_q + 1'b1;
          if (tick) begin
            dacStrobe_q <= 1'b1;
            // Running dry parks the DAC at midscale and re-primes before streaming again.
            if (fifoEmpty) begin
              dacData_q <= MIDSCALE;
              state_q   <= PRIME;
            end else begin
              dacData_q <= fifoHead;
            end
          end
        end
        default: state_q <= PRIME;
      endcase
    end
  end

  assign bus.dac_data   = dacData_q;
  assign bus.dac_strobe = dacStrobe_q;
  assign bus.fill_level = fifoCount;
  assign bus.underflow  = underflow_q;
  assign bus.overflow   = overflow_q;

endmodule
